// File: rtl/bcd_updown_counter_display.sv
// N-digit BCD up/down counter with load, count prescaler and multiplexed seven-segment scan.
// Optional BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module bcd_updown_counter_display #(
    parameter int DIGITS   = 4,
    parameter int CNT_PSC  = 100000000,
    parameter int SCAN_PSC = 100000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  up_i,
    input  logic                  ld_i,
    input  logic [4*DIGITS-1:0]   ld_val_i,
    output logic [4*DIGITS-1:0]   cnt_o,
    output logic                  wrap_o,
    output logic [DIGITS-1:0]     an_o,
    output logic [6:0]            ca_o
);

    localparam int CW = (CNT_PSC  > 1) ? $clog2(CNT_PSC)  : 1;
    localparam int SW = (SCAN_PSC > 1) ? $clog2(SCAN_PSC) : 1;
    localparam int IW = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_PSC - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_PSC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0]          cnt_psc;
    logic [SW-1:0]          scan_psc;
    logic [IW-1:0]          scan_idx;
    logic                   tick;
    logic [4*DIGITS-1:0]    cnt_inc, cnt_dec, ld_clean;
    logic                   inc_carry, dec_borrow;
    logic [3:0]             cur_digit;
    logic [DIGITS-1:0]      blank;
    logic [DIGITS-1:0]      an_nxt;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h01;
            4'd1:    seg_code = 7'h4F;
            4'd2:    seg_code = 7'h12;
            4'd3:    seg_code = 7'h06;
            4'd4:    seg_code = 7'h4C;
            4'd5:    seg_code = 7'h24;
            4'd6:    seg_code = 7'h20;
            4'd7:    seg_code = 7'h0F;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h04;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    assign tick = en_i && (cnt_psc == CNT_LAST);

    // Ripple decimal carry/borrow; a carry or borrow surviving the top digit means wrap.
    always_comb begin
        cnt_inc    = cnt_o;
        cnt_dec    = cnt_o;
        ld_clean   = ld_val_i;
        inc_carry  = 1'b1;
        dec_borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (inc_carry) begin
                if (cnt_o[4*i +: 4] == 4'd9) begin
                    cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*i +: 4] = cnt_o[4*i +: 4] + 4'd1;
                    inc_carry         = 1'b0;
                end
            end
            if (dec_borrow) begin
                if (cnt_o[4*i +: 4] == 4'd0) begin
                    cnt_dec[4*i +: 4] = 4'd9;
                end else begin
                    cnt_dec[4*i +: 4] = cnt_o[4*i +: 4] - 4'd1;
                    dec_borrow        = 1'b0;
                end
            end
            if (ld_val_i[4*i +: 4] > 4'd9)
                ld_clean[4*i +: 4] = 4'd0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o   <= '0;
            wrap_o  <= 1'b0;
            cnt_psc <= '0;
        end else begin
            wrap_o <= 1'b0;
            if (ld_i) begin
                cnt_o   <= ld_clean;
                cnt_psc <= '0;
            end else if (tick) begin
                cnt_psc <= '0;
                cnt_o   <= up_i ? cnt_inc : cnt_dec;
                wrap_o  <= up_i ? inc_carry : dec_borrow;
            end else if (en_i) begin
                cnt_psc <= cnt_psc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scan_psc <= '0;
            scan_idx <= '0;
        end else if (scan_psc == SCAN_LAST) begin
            scan_psc <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
        end else begin
            scan_psc <= scan_psc + 1'b1;
        end
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic upper_zero;

    // Digit k blanks only when it and everything above it are zero; digit 0 never blanks.
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (cnt_o[4*k +: 4] == 4'd0);
            blank[k]   = upper_zero;
        end
    end
`else
    assign blank = '0;
`endif

    assign cur_digit = cnt_o[4*scan_idx +: 4];
    assign an_nxt    = ~(DIGITS'(1) << scan_idx);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            an_o <= '1;
            ca_o <= 7'h7F;
        end else begin
            an_o <= an_nxt;
            ca_o <= blank[scan_idx] ? 7'h7F : seg_code(cur_digit);
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter_display.sv
// Directed bench for bcd_updown_counter_display with DIGITS=4, CNT_PSC=4, SCAN_PSC=2.
// Expected segment codes follow BCD_LEADING_ZERO_BLANK_EN when defined.
module tb_bcd_updown_counter_display;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        en_i = 1'b0, up_i = 1'b0, ld_i = 1'b0;
    logic [15:0] ld_val_i = '0;
    logic [15:0] cnt_o;
    logic        wrap_o;
    logic [3:0]  an_o;
    logic [6:0]  ca_o;

    int n_checks = 0;
    int n_pass   = 0;

    bcd_updown_counter_display #(.DIGITS(4), .CNT_PSC(4), .SCAN_PSC(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .up_i(up_i), .ld_i(ld_i),
        .ld_val_i(ld_val_i), .cnt_o(cnt_o), .wrap_o(wrap_o), .an_o(an_o), .ca_o(ca_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        return 32'(((v / 10) << 4) | (v % 10));
    endfunction

    logic [3:0] exp_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic [6:0] exp_ca [4] = '{7'h20, 7'h4C, 7'h7F, 7'h7F};
`else
    logic [6:0] exp_ca [4] = '{7'h20, 7'h4C, 7'h01, 7'h01};
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  k;
        logic wrap_seen;

        // Reset values
        step(3);
        check("rst_cnt",  32'(cnt_o),  32'h0);
        check("rst_wrap", 32'(wrap_o), 32'h0);
        check("rst_an",   32'(an_o),   32'hF);
        check("rst_ca",   32'(ca_o),   32'h7F);

        // Up count, 40 cycles
        rst_i = 1'b0; en_i = 1'b1; up_i = 1'b1;
        wrap_seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (i == 1) check("first_an", 32'(an_o), 32'hE);
            wrap_seen = wrap_seen | wrap_o;
            if (i % 4 == 0) check("up_cnt", 32'(cnt_o), to_bcd(i / 4));
        end
        check("up_nowrap", 32'(wrap_seen), 32'h0);

        // Wrap up from 9999, then down from 0000
        ld_i = 1'b1; ld_val_i = 16'h9998;
        step(1); ld_i = 1'b0;
        check("ld9998", 32'(cnt_o), 32'h9998);
        step(4);
        check("cnt9999",   32'(cnt_o),  32'h9999);
        check("nowrap999", 32'(wrap_o), 32'h0);
        step(4);
        check("wrap_up_cnt", 32'(cnt_o),  32'h0000);
        check("wrap_up",     32'(wrap_o), 32'h1);
        up_i = 1'b0;
        step(1);
        check("wrap_up_1cyc", 32'(wrap_o), 32'h0);
        step(3);
        check("wrap_dn_cnt", 32'(cnt_o),  32'h9999);
        check("wrap_dn",     32'(wrap_o), 32'h1);
        step(1);
        check("wrap_dn_1cyc", 32'(wrap_o), 32'h0);

        // Load coincident with tick
        step(2);
        ld_i = 1'b1; ld_val_i = 16'h1234; up_i = 1'b1;
        step(1); ld_i = 1'b0;
        check("ld_tick_cnt",  32'(cnt_o),  32'h1234);
        check("ld_tick_wrap", 32'(wrap_o), 32'h0);
        step(3);
        check("ld_hold", 32'(cnt_o), 32'h1234);
        step(1);
        check("ld_next_tick", 32'(cnt_o), 32'h1235);
        ld_i = 1'b1; ld_val_i = 16'h1A3F;
        step(1); ld_i = 1'b0;
        check("ld_sanitize", 32'(cnt_o), 32'h1030);

        // Enable freeze mid-prescale
        step(2);
        en_i = 1'b0;
        step(10);
        check("freeze", 32'(cnt_o), 32'h1030);
        en_i = 1'b1;
        step(1);
        check("resume_hold", 32'(cnt_o), 32'h1030);
        step(1);
        check("resume_tick", 32'(cnt_o), 32'h1031);

        // Load with count disabled, then scan
        en_i = 1'b0; ld_i = 1'b1; ld_val_i = 16'h0046;
        step(1); ld_i = 1'b0;
        check("ld_disabled", 32'(cnt_o), 32'h0046);
        k = 0;
        while (an_o !== 4'h7 && k < 20) begin step(1); k++; end
        check("sync_an7", 32'(k < 20), 32'h1);
        k = 0;
        while (an_o !== 4'hE && k < 20) begin step(1); k++; end
        check("sync_anE", 32'(k < 20), 32'h1);
        for (int c = 0; c < 8; c++) begin
            check("scan_an", 32'(an_o), 32'(exp_an[c / 2]));
            check("scan_ca", 32'(ca_o), 32'(exp_ca[c / 2]));
            step(1);
        end

        // Asynchronous reset mid-count and mid-scan
        en_i = 1'b1;
        step(5);
        #2 rst_i = 1'b1;
        #1;
        check("arst_cnt",  32'(cnt_o),  32'h0);
        check("arst_wrap", 32'(wrap_o), 32'h0);
        check("arst_an",   32'(an_o),   32'hF);
        check("arst_ca",   32'(ca_o),   32'h7F);
        step(1);
        check("arst_hold_an", 32'(an_o), 32'hF);
        rst_i = 1'b0;
        step(1);
        check("post_rst_an", 32'(an_o), 32'hE);
        step(2);
        check("post_rst_cnt0", 32'(cnt_o), 32'h0);
        step(1);
        check("post_rst_cnt1", 32'(cnt_o), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
